// File: rtl/mem_write_checker.sv
// Scoreboard-style checker for a memory write bus: an ordered table of expected
// (address, data) writes is loaded in IDLE and then matched in sequence during RUN.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 1,
    localparam int MCW    = $clog2(DEPTH + 1),
    localparam int CCW    = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] data_addr,
    input  logic [WIDTH-1:0] write_data,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [MCW-1:0]   match_count,
    output logic [CCW-1:0]   cycle_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [MCW-1:0]   load_ptr_r;
    logic [MCW-1:0]   load_ptr_s;
    logic             ovf_r;
    logic             ovf_s;
    logic [MCW-1:0]   match_count_r;
    logic [MCW-1:0]   match_count_s;
    logic [CCW-1:0]   cycle_count_r;
    logic [CCW-1:0]   cycle_count_s;
    logic [1:0]       fail_code_r;
    logic [1:0]       fail_code_s;
    logic             done_r;
    logic             pass_r;
    logic             wr_en_s;
    logic [IW-1:0]    idx_s;
    logic             hit_s;
    logic             final_s;
    logic             timeout_s;
    logic [CCW-1:0]   cycle_inc_s;

    logic [WIDTH-1:0] exp_addr_r [DEPTH];
    logic [WIDTH-1:0] exp_data_r [DEPTH];

    // Compare the observed write against the entry the run is currently waiting for.
    always_comb begin
        idx_s     = match_count_r[IW-1:0];
        hit_s     = mem_write && (data_addr == exp_addr_r[idx_s])
                              && (write_data == exp_data_r[idx_s]);
        final_s   = hit_s && ((match_count_r + MCW'(1)) == load_ptr_r);
        timeout_s = (cycle_count_r == CCW'(TIMEOUT - 1));
        if (cycle_count_r == CCW'(TIMEOUT)) begin
            cycle_inc_s = cycle_count_r;
        end else begin
            cycle_inc_s = cycle_count_r + CCW'(1);
        end
    end

    // Next-state and next-output logic; clear overrides everything.
    always_comb begin
        state_s       = state_r;
        load_ptr_s    = load_ptr_r;
        ovf_s         = ovf_r;
        match_count_s = match_count_r;
        cycle_count_s = cycle_count_r;
        fail_code_s   = fail_code_r;
        wr_en_s       = 1'b0;
        if (clear) begin
            state_s       = ST_IDLE;
            load_ptr_s    = '0;
            ovf_s         = 1'b0;
            match_count_s = '0;
            cycle_count_s = '0;
            fail_code_s   = FC_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (ovf_r) begin
                            state_s     = ST_FAIL;
                            fail_code_s = FC_OVERFLOW;
                        end else if (load_ptr_r == '0) begin
                            state_s = ST_PASS;
                        end else begin
                            state_s       = ST_RUN;
                            match_count_s = '0;
                            cycle_count_s = '0;
                        end
                    end else if (load_en) begin
                        if (load_ptr_r < MCW'(DEPTH)) begin
                            wr_en_s    = 1'b1;
                            load_ptr_s = load_ptr_r + MCW'(1);
                        end else begin
                            ovf_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cycle_count_s = cycle_inc_s;
                    // A mismatch outranks a coincident timeout; a final match outranks both.
                    if (hit_s) begin
                        match_count_s = match_count_r + MCW'(1);
                        if (final_s) begin
                            state_s = ST_PASS;
                        end else if (timeout_s) begin
                            state_s     = ST_FAIL;
                            fail_code_s = FC_TIMEOUT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else if (mem_write && (STRICT != 0)) begin
                        state_s     = ST_FAIL;
                        fail_code_s = FC_MISMATCH;
                    end else if (timeout_s) begin
                        state_s     = ST_FAIL;
                        fail_code_s = FC_TIMEOUT;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PASS: begin
                    state_s = ST_PASS;
                end
                ST_FAIL: begin
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s       = ST_IDLE;
                    load_ptr_s    = '0;
                    ovf_s         = 1'b0;
                    match_count_s = '0;
                    cycle_count_s = '0;
                    fail_code_s   = FC_NONE;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            load_ptr_r    <= '0;
            ovf_r         <= 1'b0;
            match_count_r <= '0;
            cycle_count_r <= '0;
            fail_code_r   <= FC_NONE;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            load_ptr_r    <= load_ptr_s;
            ovf_r         <= ovf_s;
            match_count_r <= match_count_s;
            cycle_count_r <= cycle_count_s;
            fail_code_r   <= fail_code_s;
            done_r        <= (state_s == ST_PASS) || (state_s == ST_FAIL);
            pass_r        <= (state_s == ST_PASS);
        end
    end

    // Expected-write table; contents are only meaningful below the load pointer.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            exp_addr_r[load_ptr_r[IW-1:0]] <= load_addr;
            exp_data_r[load_ptr_r[IW-1:0]] <= load_data;
        end
    end

    assign done        = done_r;
    assign pass        = pass_r;
    assign fail_code   = fail_code_r;
    assign match_count = match_count_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives a strict and a lenient checker with identical stimulus; each result is
// checked against a queued expectation when that checker raises done.
module tb_mem_write_checker;

    typedef struct packed {
        logic       pass;
        logic [1:0] fc;
        logic [1:0] mc;
        logic [3:0] cc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, clear, load_en, start, mem_write;
    logic [31:0] load_addr, load_data, data_addr, write_data;
    logic        done_a, pass_a, done_b, pass_b;
    logic [1:0]  fc_a, fc_b, mc_a, mc_b;
    logic [3:0]  cc_a, cc_b;
    logic        done_a_prev = 1'b0;
    logic        done_b_prev = 1'b0;

    res_t q_a[$];
    res_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.WIDTH(32), .DEPTH(2), .TIMEOUT(8), .STRICT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
        .done(done_a), .pass(pass_a), .fail_code(fc_a),
        .match_count(mc_a), .cycle_count(cc_a));

    mem_write_checker #(.WIDTH(32), .DEPTH(2), .TIMEOUT(8), .STRICT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
        .done(done_b), .pass(pass_b), .fail_code(fc_b),
        .match_count(mc_b), .cycle_count(cc_b));

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor for the strict checker.
    always @(negedge clk) begin
        if (done_a && !done_a_prev) begin
            if (q_a.size() == 0) begin
                cmp("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = q_a.pop_front();
                cmp("a_pass", pass_a, e.pass);
                cmp("a_failcode", fc_a, e.fc);
                cmp("a_matchcount", mc_a, e.mc);
                cmp("a_cyclecount", cc_a, e.cc);
            end
        end
        done_a_prev <= done_a;
    end

    // Monitor for the lenient checker.
    always @(negedge clk) begin
        if (done_b && !done_b_prev) begin
            if (q_b.size() == 0) begin
                cmp("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = q_b.pop_front();
                cmp("b_pass", pass_b, e.pass);
                cmp("b_failcode", fc_b, e.fc);
                cmp("b_matchcount", mc_b, e.mc);
                cmp("b_cyclecount", cc_b, e.cc);
            end
        end
        done_b_prev <= done_b;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; data_addr = a; write_data = d;
        cyc();
        mem_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_a_outputs"}, {done_a, pass_a, fc_a, mc_a, cc_a}, 32'd0);
        cmp({tag, "_b_outputs"}, {done_b, pass_b, fc_b, mc_b, cc_b}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; load_en = 1'b0; start = 1'b0; mem_write = 1'b0;
        load_addr = 32'd0; load_data = 32'd0; data_addr = 32'd0; write_data = 32'd0;
        idle(3);
        check_idle("reset");
        #3 rst_n = 1'b1;
        cyc();
        check_idle("after_reset");

        // Two-entry pass; the stray write fails only the strict checker.
        load(32'd80, 32'd7); load(32'd84, 32'd7); go();
        q_a.push_back('{pass: 1'b0, fc: 2'b01, mc: 2'd1, cc: 4'd2});
        q_b.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd2, cc: 4'd3});
        wr(32'd80, 32'd7); wr(32'd60, 32'd1); wr(32'd84, 32'd7);
        idle(2);
        do_clear();
        check_idle("clear_from_done");

        // Mismatch fails strict immediately; the lenient one eventually times out.
        load(32'd84, 32'd7); go();
        q_a.push_back('{pass: 1'b0, fc: 2'b01, mc: 2'd0, cc: 4'd1});
        q_b.push_back('{pass: 1'b0, fc: 2'b10, mc: 2'd0, cc: 4'd8});
        wr(32'd80, 32'd3);
        cmp("mismatch_done_next_edge", done_a, 1'b1);
        idle(10);
        do_clear();

        // Timeout exactly eight cycles after entering RUN.
        load(32'd84, 32'd7); go();
        q_a.push_back('{pass: 1'b0, fc: 2'b10, mc: 2'd0, cc: 4'd8});
        q_b.push_back('{pass: 1'b0, fc: 2'b10, mc: 2'd0, cc: 4'd8});
        idle(7);
        cmp("timeout_not_yet", done_a, 1'b0);
        cyc();
        cmp("timeout_now", done_a, 1'b1);
        idle(2);
        do_clear();

        // Overflow: third load into a two-entry table.
        load(32'd1, 32'd1); load(32'd2, 32'd2); load(32'd3, 32'd3);
        q_a.push_back('{pass: 1'b0, fc: 2'b11, mc: 2'd0, cc: 4'd0});
        q_b.push_back('{pass: 1'b0, fc: 2'b11, mc: 2'd0, cc: 4'd0});
        go();
        idle(2);
        do_clear();

        // Final match on the last allowed cycle wins over timeout.
        load(32'd80, 32'd7); go();
        q_a.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd1, cc: 4'd8});
        q_b.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd1, cc: 4'd8});
        idle(7);
        wr(32'd80, 32'd7);
        idle(2);
        do_clear();

        // Mismatch coinciding with timeout reports mismatch (strict only).
        load(32'd80, 32'd7); go();
        q_a.push_back('{pass: 1'b0, fc: 2'b01, mc: 2'd0, cc: 4'd8});
        q_b.push_back('{pass: 1'b0, fc: 2'b10, mc: 2'd0, cc: 4'd8});
        idle(7);
        wr(32'd99, 32'd9);
        idle(2);
        do_clear();

        // Start and load together: the load is dropped, so one match passes.
        load(32'd80, 32'd7);
        start = 1'b1; load_en = 1'b1; load_addr = 32'd84; load_data = 32'd7;
        cyc();
        start = 1'b0; load_en = 1'b0;
        q_a.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd1, cc: 4'd1});
        q_b.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd1, cc: 4'd1});
        wr(32'd80, 32'd7);
        idle(2);
        do_clear();

        // Reset mid-RUN is immediate and empties the table.
        load(32'd80, 32'd7); go();
        idle(3);
        #2 rst_n = 1'b0;
        #1 check_idle("reset_mid_run");
        #2 rst_n = 1'b1;
        q_a.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd0, cc: 4'd0});
        q_b.push_back('{pass: 1'b1, fc: 2'b00, mc: 2'd0, cc: 4'd0});
        go();
        idle(3);
        do_clear();
        check_idle("final_clear");

        cmp("a_queue_drained", q_a.size(), 32'd0);
        cmp("b_queue_drained", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter WIDTH, default 32, address and data width of the observed memory write bus.
REQ-002 Parameter DEPTH, default 4, maximum number of expected write entries (at least 1).
REQ-003 Parameter TIMEOUT, default 1024, cycles allowed in RUN before timeout failure (at least 1).
REQ-004 Parameter STRICT, default 1; 1 = any non-matching write fails, 0 = non-matching writes ignored.
REQ-005 CLK  input  1  single clock; all state changes on the rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Clear  input  1  synchronous return to IDLE; empties the expected table.
REQ-008 LoadEn  input  1  appends one expected entry while in IDLE.
REQ-009 LoadAddr  input  WIDTH  expected write address for the appended entry.
REQ-010 LoadData  input  WIDTH  expected write data for the appended entry.
REQ-011 Start  input  1  IDLE to RUN transition request.
REQ-012 MemWrite  input  1  observed DUT memory write strobe.
REQ-013 DataAddr  input  WIDTH  observed write address.
REQ-014 WriteData  input  WIDTH  observed write data.
REQ-015 Done  output  1  high in PASS or FAIL.
REQ-016 Pass  output  1  high in PASS only.
REQ-017 FailCode  output  2  00 none, 01 mismatch, 10 timeout, 11 load overflow.
REQ-018 MatchCount  output  clog2(DEPTH+1)  number of expected entries matched so far.
REQ-019 CycleCount  output  clog2(TIMEOUT+1)  cycles spent in RUN, saturating at TIMEOUT.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RUN, PASS, FAIL.
REQ-021 In IDLE, LoadEn with fewer than DEPTH entries stored SHALL write the entry at the load pointer and increment the pointer.
REQ-022 In IDLE, LoadEn with DEPTH entries already stored SHALL leave the table unchanged and set a sticky overflow flag.
REQ-023 LoadEn outside IDLE SHALL be ignored.
REQ-024 In IDLE, Start with the overflow flag set SHALL move to FAIL with FailCode 11 on the next edge.
REQ-025 In IDLE, Start with zero stored entries SHALL move to PASS on the next edge.
REQ-026 Otherwise, Start in IDLE SHALL move to RUN and zero MatchCount and CycleCount.
REQ-027 Start and LoadEn asserted in the same IDLE cycle: Start SHALL take effect and the load SHALL be discarded.
REQ-028 In RUN, CycleCount SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-029 In RUN, a write matches when MemWrite=1, DataAddr equals the expected address at index MatchCount, and WriteData equals the expected data at that index.
REQ-030 A matching write SHALL increment MatchCount.
REQ-031 When a matching write brings MatchCount to the stored entry count, the FSM SHALL move to PASS on the same edge.
REQ-032 With STRICT=1, MemWrite=1 without a match SHALL move the FSM to FAIL with FailCode 01 and leave MatchCount unchanged.
REQ-033 With STRICT=0, non-matching writes SHALL be ignored.
REQ-034 When CycleCount equals TIMEOUT-1 and the cycle produces no final match, the FSM SHALL move to FAIL with FailCode 10.
REQ-035 A final match and a timeout in the same cycle: PASS SHALL take priority.
REQ-036 A mismatch and a timeout in the same cycle: FailCode SHALL be 01.
REQ-037 PASS and FAIL SHALL hold all outputs until Clear or Reset; Start, LoadEn and MemWrite SHALL be ignored in these states.
REQ-038 Clear SHALL have priority over all other inputs in every state.
REQ-039 Clear SHALL move the FSM to IDLE and zero the load pointer, overflow flag, MatchCount, CycleCount and FailCode; table contents need not be cleared.
REQ-040 All address and data compares SHALL be full-WIDTH equality, with no masking.

Reset
REQ-041 When Reset=0, the block SHALL asynchronously enter IDLE and set Done=0, Pass=0, FailCode=00, MatchCount=0 and CycleCount=0.
REQ-042 Reset=0 SHALL asynchronously zero the load pointer and the overflow flag, independent of CLK and mid-RUN.
REQ-043 After Reset deasserts, the first state change SHALL occur at the next rising CLK edge.

Verification
REQ-044 Pass case: DEPTH=2, STRICT=0; load (80,7) and (84,7); Start; writes (80,7), (60,1), (84,7) -> Pass=1, Done=1, MatchCount=2, FailCode=00.
REQ-045 Mismatch case: STRICT=1; load (84,7); Start; write (80,3) -> FailCode=01, MatchCount=0, Done=1 on the next edge.
REQ-046 Timeout case: TIMEOUT=8; load (84,7); Start; no writes -> FAIL with FailCode=10 eight cycles after RUN entry, CycleCount=8.
REQ-047 Overflow case: DEPTH=2; three LoadEn pulses; Start -> FAIL with FailCode=11.
REQ-048 Boundary case: the final match lands on CycleCount=TIMEOUT-1 -> PASS; separately, Reset pulsed mid-RUN -> IDLE with all outputs zero, and Clear in PASS -> IDLE.
